// File: rtl/ex_stage_pipe_if.sv
// Bus between ID, the execute stage and MEM: the ID->EX op with its
// valid/ready pair, the EX/MEM register outputs with their ready, the branch
// redirect and the status outputs. The master side is the ID/MEM
// environment; the slave side is the execute stage.
interface ex_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [REG_AW-1:0] in_rs1_idx;
  logic [REG_AW-1:0] in_rs2_idx;
  logic [XLEN-1:0]   in_rs1_val;
  logic [XLEN-1:0]   in_rs2_val;
  logic [XLEN-1:0]   in_imm;
  logic              in_use_imm;
  logic [3:0]        in_alu_op;
  logic [REG_AW-1:0] in_rd;
  logic              in_wen;
  logic              in_is_br;
  logic [2:0]        in_br_cond;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_result;
  logic [REG_AW-1:0] out_rd;
  logic              out_wen;
  logic              br_redirect;
  logic [XLEN-1:0]   br_target;
  logic              illegal_op;
  logic [CNT_W-1:0]  exec_count;

  modport master (
    output flush, in_valid, in_pc, in_rs1_idx, in_rs2_idx, in_rs1_val, in_rs2_val,
           in_imm, in_use_imm, in_alu_op, in_rd, in_wen, in_is_br, in_br_cond, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wen, br_redirect, br_target,
           illegal_op, exec_count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rs1_idx, in_rs2_idx, in_rs1_val, in_rs2_val,
           in_imm, in_use_imm, in_alu_op, in_rd, in_wen, in_is_br, in_br_cond, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wen, br_redirect, br_target,
           illegal_op, exec_count
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// Execute stage: operand forwarding from the EX/MEM register, a
// combinational ALU, branch resolution from the ALU result, and the EX/MEM
// pipeline register under valid/ready flow control. Also keeps a sticky
// illegal-op flag and a wrapping count of accepted ops.
module ex_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic            clk,
  input logic            rst,
  ex_stage_pipe_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_CONST = 4'd15
  } alu_op_e;

  logic              out_valid_q,   out_valid_d;
  logic [XLEN-1:0]   out_result_q,  out_result_d;
  logic [REG_AW-1:0] out_rd_q,      out_rd_d;
  logic              out_wen_q,     out_wen_d;
  logic              br_redirect_q, br_redirect_d;
  logic [XLEN-1:0]   br_target_q,   br_target_d;
  logic              illegal_op_q,  illegal_op_d;
  logic [CNT_W-1:0]  exec_count_q,  exec_count_d;

  logic              in_ready;
  logic              accept;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  alu_op_e           alu_op;
  logic [XLEN-1:0]   alu_result;
  logic              alu_zero;
  logic [7:0]        alu_error_vector;
  logic              br_taken;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Operand selection: forward the EX/MEM result to a matching non-zero source index,
  // and let branches override the ALU op with the compare they need.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    fwd_rs1 = bus.in_rs1_val;
    fwd_rs2 = bus.in_rs2_val;
    if (out_valid_q && out_wen_q && (out_rd_q != '0) && (out_rd_q == bus.in_rs1_idx)) begin
      fwd_rs1 = out_result_q;
    end
    if (out_valid_q && out_wen_q && (out_rd_q != '0) && (out_rd_q == bus.in_rs2_idx)) begin
      fwd_rs2 = out_result_q;
    end
    alu_a  = fwd_rs1;
    alu_b  = bus.in_use_imm ? bus.in_imm : fwd_rs2;
    alu_op = alu_op_e'(bus.in_alu_op);
    if (bus.in_is_br) begin
      case (bus.in_br_cond[2:1])
        2'b10:   alu_op = ALU_SLT;
        2'b11:   alu_op = ALU_SLTU;
        default: alu_op = ALU_SUB;   // beq/bne, and the never-taken 010/011 codes
      endcase
    end
  end

  // Combinational ALU; reserved codes 10..14 yield zero and raise the error vector.
  always_comb begin
    alu_result       = '0;
    alu_error_vector = 8'h00;
    case (alu_op)
      ALU_ADD:   alu_result = alu_a + alu_b;
      ALU_SUB:   alu_result = alu_a - alu_b;
      ALU_AND:   alu_result = alu_a & alu_b;
      ALU_OR:    alu_result = alu_a | alu_b;
      ALU_XOR:   alu_result = alu_a ^ alu_b;
      ALU_SLL:   alu_result = alu_a << alu_b[4:0];
      ALU_SRL:   alu_result = alu_a >> alu_b[4:0];
      ALU_SRA:   alu_result = XLEN'($signed(alu_a) >>> alu_b[4:0]);
      ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ALU_CONST: alu_result = alu_b;
      default:   alu_error_vector = 8'hff;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Branch resolution from the zero flag or the compare result bit.
  always_comb begin
    br_taken = 1'b0;
    if (bus.in_is_br) begin
      case (bus.in_br_cond)
        3'b000:         br_taken = alu_zero;
        3'b001:         br_taken = !alu_zero;
        3'b100, 3'b110: br_taken = alu_result[0];
        3'b101, 3'b111: br_taken = !alu_result[0];
        default:        br_taken = 1'b0;
      endcase
    end
  end

  // Next-state of the EX/MEM register: flush kills, accept loads, drain clears, stall holds.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_wen_d     = out_wen_q;
    br_redirect_d = 1'b0;            // redirect is a single-cycle pulse
    br_target_d   = br_target_q;
    illegal_op_d  = illegal_op_q;
    exec_count_d  = exec_count_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_result_d  = alu_result;
      out_rd_d      = bus.in_rd;
      out_wen_d     = bus.in_wen && !bus.in_is_br;
      exec_count_d  = exec_count_q + CNT_W'(1);
      illegal_op_d  = illegal_op_q || (alu_error_vector == 8'hff);
      br_redirect_d = br_taken;
      if (br_taken) begin
        br_target_d = bus.in_pc + bus.in_imm;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over everything else.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_wen_q     <= 1'b0;
      br_redirect_q <= 1'b0;
      br_target_q   <= '0;
      illegal_op_q  <= 1'b0;
      exec_count_q  <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_rd_q      <= out_rd_d;
      out_wen_q     <= out_wen_d;
      br_redirect_q <= br_redirect_d;
      br_target_q   <= br_target_d;
      illegal_op_q  <= illegal_op_d;
      exec_count_q  <= exec_count_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_wen     = out_wen_q;
  assign bus.br_redirect = br_redirect_q;
  assign bus.br_target   = br_target_q;
  assign bus.illegal_op  = illegal_op_q;
  assign bus.exec_count  = exec_count_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe: directed scenarios plus randomized
// traffic against a transaction-level reference model, and a narrow-counter
// instance for wrap-around and the sticky illegal-op flag.
module tb_ex_stage_pipe;

  logic clk = 1'b0;
  logic rst;
  logic rst_w;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_pipe_if #(.XLEN(32), .REG_AW(5), .CNT_W(32)) bus ();
  ex_stage_pipe_if #(.XLEN(32), .REG_AW(5), .CNT_W(3))  bus_w ();

  ex_stage_pipe #(.XLEN(32), .REG_AW(5), .CNT_W(32)) dut   (.clk(clk), .rst(rst),   .bus(bus));
  ex_stage_pipe #(.XLEN(32), .REG_AW(5), .CNT_W(3))  dut_w (.clk(clk), .rst(rst_w), .bus(bus_w));

  // Reference model state: the architecturally visible EX/MEM contents.
  logic        m_valid, m_wen, m_redirect, m_illegal;
  logic [31:0] m_result, m_target, m_count;
  logic [4:0]  m_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b & 32'd31);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << sh;
      6:  return a >> sh;
      7:  return $signed(a) >>> sh;
      8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      15: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] regval);
    if (m_valid && m_wen && idx != 5'd0 && idx == m_rd) return m_result;
    return regval;
  endfunction

  // One clock of the main DUT: check in_ready, predict, clock, then compare all outputs.
  task automatic cycle();
    logic        rdy, acc, taken;
    logic [31:0] a, b, res;
    int          op;
    #1;
    rdy = !m_valid || bus.out_ready;
    check("in_ready", {63'd0, bus.in_ready}, {63'd0, rdy});
    a = fwd(bus.in_rs1_idx, bus.in_rs1_val);
    b = bus.in_use_imm ? bus.in_imm : fwd(bus.in_rs2_idx, bus.in_rs2_val);
    op = int'(bus.in_alu_op);
    taken = 1'b0;
    if (bus.in_is_br) begin
      case (bus.in_br_cond)
        3'd0: begin op = 1; taken = (a == b); end
        3'd1: begin op = 1; taken = (a != b); end
        3'd4: begin op = 8; taken = ($signed(a) <  $signed(b)); end
        3'd5: begin op = 8; taken = ($signed(a) >= $signed(b)); end
        3'd6: begin op = 9; taken = (a <  b); end
        3'd7: begin op = 9; taken = (a >= b); end
        default: begin op = 1; taken = 1'b0; end
      endcase
    end
    res = alu_ref(op, a, b);
    acc = bus.in_valid && rdy && !bus.flush;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_wen = 0; m_redirect = 0; m_illegal = 0;
      m_result = 0; m_target = 0; m_count = 0; m_rd = 0;
    end else begin
      m_redirect = 0;
      if (bus.flush) begin
        m_valid = 0;
      end else if (acc) begin
        m_valid  = 1;
        m_result = res;
        m_rd     = bus.in_rd;
        m_wen    = bus.in_wen && !bus.in_is_br;
        m_count  = m_count + 32'd1;
        if (op >= 10 && op <= 14) m_illegal = 1;
        if (taken) begin
          m_redirect = 1;
          m_target   = bus.in_pc + bus.in_imm;
        end
      end else if (bus.out_ready) begin
        m_valid = 0;
      end
    end
    #1;
    check("out_valid",   {63'd0, bus.out_valid},   {63'd0, m_valid});
    check("out_result",  {32'd0, bus.out_result},  {32'd0, m_result});
    check("out_rd",      {59'd0, bus.out_rd},      {59'd0, m_rd});
    check("out_wen",     {63'd0, bus.out_wen},     {63'd0, m_wen});
    check("br_redirect", {63'd0, bus.br_redirect}, {63'd0, m_redirect});
    check("br_target",   {32'd0, bus.br_target},   {32'd0, m_target});
    check("illegal_op",  {63'd0, bus.illegal_op},  {63'd0, m_illegal});
    check("exec_count",  {32'd0, bus.exec_count},  {32'd0, m_count});
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [4:0] r1i, input logic [31:0] r1v,
                        input logic [4:0] r2i, input logic [31:0] r2v, input logic [31:0] imm,
                        input logic use_imm, input logic [3:0] op, input logic [4:0] rd,
                        input logic wen, input logic is_br, input logic [2:0] cond);
    bus.in_pc = pc;       bus.in_rs1_idx = r1i; bus.in_rs1_val = r1v;
    bus.in_rs2_idx = r2i; bus.in_rs2_val = r2v; bus.in_imm = imm;
    bus.in_use_imm = use_imm; bus.in_alu_op = op; bus.in_rd = rd;
    bus.in_wen = wen;     bus.in_is_br = is_br; bus.in_br_cond = cond;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 4));
      1:       return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction

  int          ops_tbl[11]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 15};
  int          conds_tbl[6] = '{0, 1, 4, 5, 6, 7};
  logic [31:0] held_result;
  logic [31:0] held_count;

  initial begin
    rst = 1'b1;
    rst_w = 1'b1;
    bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus_w.flush = 0; bus_w.in_valid = 0; bus_w.out_ready = 1;
    bus_w.in_pc = 0; bus_w.in_rs1_idx = 0; bus_w.in_rs1_val = 0; bus_w.in_rs2_idx = 0;
    bus_w.in_rs2_val = 0; bus_w.in_imm = 0; bus_w.in_use_imm = 0; bus_w.in_alu_op = 0;
    bus_w.in_rd = 0; bus_w.in_wen = 0; bus_w.in_is_br = 0; bus_w.in_br_cond = 0;
    @(posedge clk); #1;
    m_valid = 0; m_wen = 0; m_redirect = 0; m_illegal = 0;
    m_result = 0; m_target = 0; m_count = 0; m_rd = 0;
    cycle();
    rst = 1'b0;

    // Reset in the middle of a stall returns everything to reset values.
    set_op(32'h40, 1, 32'd9, 2, 32'd4, 0, 0, 4'd0, 5'd6, 1, 0, 0);
    bus.in_valid = 1; bus.out_ready = 1;
    cycle();
    bus.out_ready = 0;
    cycle();
    rst = 1'b1;
    cycle();
    check("rst_stall_valid",  {63'd0, bus.out_valid},  64'd0);
    check("rst_stall_result", {32'd0, bus.out_result}, 64'd0);
    rst = 1'b0;
    bus.out_ready = 1;

    // add 5+7 into x3, then sub x3 (reg file still 0) - x2 (=2) via forwarding.
    set_op(0, 1, 32'd5, 2, 32'd7, 0, 0, 4'd0, 5'd3, 1, 0, 0);
    cycle();
    check("add_5_7", {32'd0, bus.out_result}, 64'd12);
    set_op(4, 3, 32'd0, 2, 32'd2, 0, 0, 4'd1, 5'd4, 1, 0, 0);
    cycle();
    check("fwd_sub", {32'd0, bus.out_result}, 64'd10);

    // beq taken: one-cycle redirect, target pc+imm, no register write.
    set_op(32'h100, 5, 32'h20, 6, 32'h20, 32'h40, 0, 4'd4, 5'd7, 1, 1, 3'b000);
    cycle();
    check("beq_redirect", {63'd0, bus.br_redirect}, 64'd1);
    check("beq_target",   {32'd0, bus.br_target},   64'h140);
    check("beq_wen",      {63'd0, bus.out_wen},     64'd0);
    bus.in_valid = 0;
    cycle();
    check("beq_pulse_end", {63'd0, bus.br_redirect}, 64'd0);
    bus.in_valid = 1;

    // blt -1 < 1 taken; bltu 0xffffffff < 1 not taken.
    set_op(32'h200, 8, 32'hffff_ffff, 9, 32'd1, 32'h10, 0, 4'd0, 5'd1, 0, 1, 3'b100);
    cycle();
    check("blt_redirect", {63'd0, bus.br_redirect}, 64'd1);
    check("blt_target",   {32'd0, bus.br_target},   64'h210);
    set_op(32'h300, 8, 32'hffff_ffff, 9, 32'd1, 32'h10, 0, 4'd0, 5'd1, 0, 1, 3'b110);
    cycle();
    check("bltu_redirect", {63'd0, bus.br_redirect}, 64'd0);
    check("bltu_target",   {32'd0, bus.br_target},   64'h210);

    // Three stalled cycles with a pending op: nothing moves, nothing counted.
    set_op(0, 0, 32'd100, 0, 32'd23, 0, 0, 4'd0, 5'd9, 1, 0, 0);
    cycle();
    held_result = m_result;
    held_count  = m_count;
    set_op(0, 0, 32'd1, 0, 32'd1, 0, 0, 4'd0, 5'd10, 1, 0, 0);
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_in_ready", {63'd0, bus.in_ready},   64'd0);
      check("stall_result",   {32'd0, bus.out_result}, {32'd0, held_result});
      check("stall_count",    {32'd0, bus.exec_count}, {32'd0, held_count});
    end
    bus.out_ready = 1;
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst            = ($urandom_range(0, 299) == 0);
      bus.flush      = ($urandom_range(0, 19) == 0);
      bus.in_valid   = ($urandom_range(0, 4) != 0);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.in_pc      = $urandom;
      bus.in_rs1_idx = 5'($urandom_range(0, 7));
      bus.in_rs2_idx = 5'($urandom_range(0, 7));
      bus.in_rs1_val = rand_val();
      bus.in_rs2_val = rand_val();
      bus.in_imm     = rand_val();
      bus.in_use_imm = $urandom_range(0, 1) == 1;
      bus.in_alu_op  = 4'(ops_tbl[$urandom_range(0, 10)]);
      bus.in_rd      = 5'($urandom_range(0, 7));
      bus.in_wen     = $urandom_range(0, 3) != 0;
      bus.in_is_br   = $urandom_range(0, 3) == 0;
      bus.in_br_cond = 3'(conds_tbl[$urandom_range(0, 5)]);
      if (bus.in_is_br) bus.in_use_imm = 0;
      cycle();
    end
    rst = 0;
    bus.flush = 0;
    bus.in_valid = 0;

    // Narrow counter instance: wrap all-ones -> 0 on an illegal op, flag stays set.
    @(posedge clk); #1;
    rst_w = 0;
    check("w_reset_count", {61'd0, bus_w.exec_count}, 64'd0);
    bus_w.in_valid = 1;
    repeat (7) @(posedge clk);
    #1;
    check("w_count_full",   {61'd0, bus_w.exec_count}, 64'd7);
    check("w_illegal_init", {63'd0, bus_w.illegal_op}, 64'd0);
    bus_w.in_alu_op = 4'd12;
    bus_w.in_rs1_val = 32'd77;
    @(posedge clk); #1;
    check("w_illegal_result", {32'd0, bus_w.out_result}, 64'd0);
    check("w_illegal_set",    {63'd0, bus_w.illegal_op}, 64'd1);
    check("w_count_wrap",     {61'd0, bus_w.exec_count}, 64'd0);
    bus_w.in_alu_op = 4'd0;
    bus_w.in_rs1_val = 32'd5;
    @(posedge clk); #1;
    check("w_illegal_sticky", {63'd0, bus_w.illegal_op}, 64'd1);
    check("w_count_after",    {61'd0, bus_w.exec_count}, 64'd1);
    check("w_add_result",     {32'd0, bus_w.out_result}, 64'd5);
    bus_w.in_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
